// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard sequencer: per-register in-flight scoreboard, RAW stall,
// branch squash with optional multi-cycle flush hold, and a stall-cycle counter.
//   state    | meaning
//   ST_RUN   | normal issue; stalls on RAW hazard, squashes on taken branch
//   ST_FLUSH | extra squash cycles after a taken branch (FLUSH_CYCLES > 1)
module id_hazard_ctrl #(
    parameter int CNT_W        = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int ZERO_EXEMPT  = 1,
    parameter int PERF_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_src1,
    input  logic [4:0]        id_src2,
    input  logic              id_src2_used,
    input  logic              id_wb_en,
    input  logic [4:0]        id_dest,
    input  logic              wb_en,
    input  logic [4:0]        wb_dest,
    input  logic              branch_taken,
    output logic              freeze,
    output logic              bubble,
    output logic              flush,
    output logic              issue,
    output logic [PERF_W-1:0] stall_count,
    output logic              sb_error
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0]       state;
    logic [FC_W-1:0]  flush_cnt;
    logic [CNT_W-1:0] cnt     [32];
    logic [CNT_W-1:0] cnt_nxt [32];
    logic [31:0]      wb_hit;
    logic [31:0]      alloc;
    logic [31:0]      busy;
    logic             hazard;
    logic             stall_inc;
    logic             cnt_err;

    // A write-back in this cycle retires its producer before the consumer reads
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            wb_hit[r] = wb_en && (wb_dest == 5'(r)) && !((ZERO_EXEMPT != 0) && (r == 0));
            busy[r]   = (cnt[r] != '0) && !((cnt[r] == CNT_W'(1)) && wb_hit[r]);
        end
    end

    assign hazard = id_valid && (busy[id_src1] || (id_src2_used && busy[id_src2]));

    always_comb begin
        freeze    = 1'b0;
        bubble    = 1'b1;
        flush     = 1'b0;
        issue     = 1'b0;
        stall_inc = 1'b0;
        if (rst) begin
            flush = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (branch_taken) begin
                        flush = 1'b1;
                    end else if (hazard) begin
                        freeze    = 1'b1;
                        stall_inc = 1'b1;
                    end else begin
                        issue  = id_valid;
                        bubble = ~id_valid;
                    end
                end
                default: flush = 1'b1;
            endcase
        end
    end

    always_comb begin
        cnt_err = 1'b0;
        for (int r = 0; r < 32; r++) begin
            alloc[r]   = issue && id_wb_en && (id_dest == 5'(r)) &&
                         !((ZERO_EXEMPT != 0) && (r == 0));
            cnt_nxt[r] = cnt[r];
            if (alloc[r] && !wb_hit[r]) begin
                if (cnt[r] == CNT_MAX) cnt_err = 1'b1;
                else                   cnt_nxt[r] = cnt[r] + CNT_W'(1);
            end else if (!alloc[r] && wb_hit[r]) begin
                if (cnt[r] == '0) cnt_err = 1'b1;
                else              cnt_nxt[r] = cnt[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            flush_cnt   <= '0;
            stall_count <= '0;
            sb_error    <= 1'b0;
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < 32; r++) cnt[r] <= cnt_nxt[r];
            sb_error <= sb_error | cnt_err;
            if (stall_inc && (stall_count != {PERF_W{1'b1}}))
                stall_count <= stall_count + PERF_W'(1);
            case (state)
                ST_RUN: begin
                    if (branch_taken) begin
                        flush_cnt <= FC_LOAD;
                        state     <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (branch_taken) begin
                        flush_cnt <= FC_LOAD;
                    end else begin
                        flush_cnt <= flush_cnt - FC_W'(1);
                        if (flush_cnt <= FC_W'(1)) state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule
